// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } dcache_state_e;

    localparam int unsigned LINES_DEF      = 16;
    localparam int unsigned LINE_WORDS_DEF = 4;

    localparam int unsigned DEF_OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int unsigned DEF_IDX_W = $clog2(LINES_DEF);
    localparam int unsigned DEF_TAG_W = 32 - DEF_IDX_W - DEF_OFF_W - 2;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous read by index/offset, synchronous writes.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned OFF_W = DEF_OFF_W,
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [31:0]      o_rdata,
    input  logic             i_word_we,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [31:0]      i_wdata,
    input  logic             i_tag_we,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_inv
);

    localparam int unsigned NLINES = 2 ** IDX_W;
    localparam int unsigned NWORDS = 2 ** OFF_W;

    logic [NLINES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag  [NLINES];
    logic [31:0]       r_data [NLINES][NWORDS];

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_rdata = r_data[i_idx][i_rd_off];

    // A line becomes valid only when its refill completes; it is dropped when a refill starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
        end else if (i_inv) begin
            r_valid[i_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_idx] <= i_tag;
        end
        if (i_word_we) begin
            r_data[i_idx][i_wr_off] <= i_wdata;
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache with
// word-serial refill/store handshake and pipeline freeze.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int unsigned LINES      = LINES_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM_i,
    input  logic        MemWriteM_i,
    input  logic [31:0] AddrM_i,
    input  logic [31:0] WriteDataM_i,
    output logic [31:0] ReadDataM_o,
    output logic        Stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned OFF_W    = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W    = $clog2(LINES);
    localparam int unsigned TAG_W    = 32 - IDX_W - OFF_W - 2;
    localparam int unsigned LINE_LSB = OFF_W + 2;

    dcache_state_e    r_state, w_state_nxt;
    logic [OFF_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_addr, w_addr_nxt;
    logic             r_req, w_req_nxt;
    logic             r_we, w_we_nxt;
    logic [31:0]      r_maddr, w_maddr_nxt;
    logic [31:0]      r_mwdata, w_mwdata_nxt;

    logic [31:0]      w_lk_addr;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic [TAG_W-1:0] w_tag;
    logic             w_valid;
    logic [TAG_W-1:0] w_tag_q;
    logic [31:0]      w_rdata;
    logic             w_hit;
    logic             w_word_we;
    logic [OFF_W-1:0] w_wr_off;
    logic [31:0]      w_wr_data;
    logic             w_tag_we;
    logic             w_inv;
    logic             w_stall;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_line_base;
    logic             w_unused;

    // Outside IDLE the latched address drives the lookup; the frozen pipeline is not trusted.
    assign w_lk_addr   = (r_state == IDLE) ? AddrM_i : r_addr;
    assign w_off       = w_lk_addr[LINE_LSB-1:2];
    assign w_idx       = w_lk_addr[LINE_LSB+IDX_W-1:LINE_LSB];
    assign w_tag       = w_lk_addr[31:LINE_LSB+IDX_W];
    assign w_hit       = w_valid && (w_tag_q == w_tag);
    assign w_line_base = {AddrM_i[31:LINE_LSB], LINE_LSB'(0)};
    assign w_unused    = ^w_lk_addr[1:0];

    dcache_array #(
        .OFF_W (OFF_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_idx     (w_idx),
        .i_rd_off  (w_off),
        .o_valid   (w_valid),
        .o_tag     (w_tag_q),
        .o_rdata   (w_rdata),
        .i_word_we (w_word_we),
        .i_wr_off  (w_wr_off),
        .i_wdata   (w_wr_data),
        .i_tag_we  (w_tag_we),
        .i_tag     (w_tag),
        .i_inv     (w_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_maddr  <= w_maddr_nxt;
            r_mwdata <= w_mwdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_maddr_nxt  = r_maddr;
        w_mwdata_nxt = r_mwdata;
        w_word_we    = 1'b0;
        w_wr_off     = r_cnt;
        w_wr_data    = mem_rdata_i;
        w_tag_we     = 1'b0;
        w_inv        = 1'b0;
        w_stall      = 1'b0;
        w_rd_data    = '0;

        case (r_state)
            IDLE: begin
                if (MemWriteM_i) begin
                    w_stall      = 1'b1;
                    w_state_nxt  = WRITE;
                    w_addr_nxt   = {AddrM_i[31:2], 2'b00};
                    w_req_nxt    = 1'b1;
                    w_we_nxt     = 1'b1;
                    w_maddr_nxt  = {AddrM_i[31:2], 2'b00};
                    w_mwdata_nxt = WriteDataM_i;
                end else if (MemReadM_i && !w_hit) begin
                    w_stall     = 1'b1;
                    w_inv       = 1'b1;
                    w_state_nxt = REFILL;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = w_line_base;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_maddr_nxt = w_line_base;
                end else if (MemReadM_i) begin
                    w_rd_data = w_rdata;
                end
            end
            REFILL: begin
                w_stall = 1'b1;
                if (mem_ack_i) begin
                    w_word_we   = 1'b1;
                    w_cnt_nxt   = OFF_W'(r_cnt + 1'b1);
                    w_maddr_nxt = r_addr | 32'({OFF_W'(r_cnt + 1'b1), 2'b00});
                    if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                        w_tag_we    = 1'b1;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                // Release the pipeline on the ack edge so the store is not reissued.
                w_stall = ~mem_ack_i;
                if (mem_ack_i) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                    if (w_hit) begin
                        w_word_we = 1'b1;
                        w_wr_off  = w_off;
                        w_wr_data = r_mwdata;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ReadDataM_o = w_rd_data;
    assign Stall_o     = w_stall;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_maddr;
    assign mem_wdata_o = r_mwdata;

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed loads/stores against a behavioural backing memory.
module tb_dcache_dm;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    logic        clk;
    logic        rst_n;
    logic        MemReadM_i;
    logic        MemWriteM_i;
    logic [31:0] AddrM_i;
    logic [31:0] WriteDataM_i;
    logic [31:0] ReadDataM_o;
    logic        Stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;
    int ack_lat = 0;

    mem_t        exp_mem[$];
    logic [31:0] exp_load[$];
    logic [31:0] mem [bit [31:0]];

    dcache_dm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemReadM_i   (MemReadM_i),
        .MemWriteM_i  (MemWriteM_i),
        .AddrM_i      (AddrM_i),
        .WriteDataM_i (WriteDataM_i),
        .ReadDataM_o  (ReadDataM_o),
        .Stall_o      (Stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hBAD00000 | a;
    endfunction

    // Backing memory: acks after ack_lat waiting cycles, one word per ack.
    int wait_cnt = 0;
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end
            if (mem_req_o) begin
                if (wait_cnt >= ack_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_rd(mem_addr_o);
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a transfer or a load.
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;
    always @(negedge clk) begin
        if (rst_n && mem_req_o && mem_ack_i) begin
            if (exp_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got transfer we=%0b addr=%h expected none", mem_we_o, mem_addr_o);
            end else begin
                chk("mem_we", {31'd0, mem_we_o}, {31'd0, exp_mem[0].we});
                chk("mem_addr", mem_addr_o, exp_mem[0].addr);
                if (exp_mem[0].we) chk("mem_wdata", mem_wdata_o, exp_mem[0].wdata);
                void'(exp_mem.pop_front());
            end
        end
        if (rst_n && p_req && !p_ack && mem_req_o) begin
            chk("stable_addr", mem_addr_o, p_addr);
            chk("stable_we", {31'd0, mem_we_o}, {31'd0, p_we});
            chk("stable_wdata", mem_wdata_o, p_wdata);
        end
        if (rst_n && MemReadM_i && !MemWriteM_i && !Stall_o) begin
            if (exp_load.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_unexpected: got data %h expected no load", ReadDataM_o);
            end else begin
                chk("load_data", ReadDataM_o, exp_load[0]);
                void'(exp_load.pop_front());
            end
        end
        p_req   <= mem_req_o;
        p_ack   <= mem_ack_i;
        p_we    <= mem_we_o;
        p_addr  <= mem_addr_o;
        p_wdata <= mem_wdata_o;
    end

    task automatic reset_checks();
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_stall", {31'd0, Stall_o}, 32'd0);
        chk("rst_rdata", ReadDataM_o, 32'd0);
    endtask

    task automatic wait_release(input string name, input int exp_stall);
        int  n = 0;
        bit  done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (Stall_o) n++;
            else done = 1;
        end
        chk({name, "_released"}, {31'd0, done}, 32'd1);
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp_d, input bit miss, input int exp_stall);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        if (miss) begin
            for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, base + 32'(4 * i), 32'h0});
        end
        exp_load.push_back(exp_d);
        @(posedge clk);
        #1;
        MemReadM_i  = 1'b1;
        MemWriteM_i = 1'b0;
        AddrM_i     = a;
        wait_release("load", exp_stall);
        @(posedge clk);
        #1;
        MemReadM_i = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit rd_too, input int lat, input int exp_stall);
        exp_mem.push_back('{1'b1, {a[31:2], 2'b00}, d});
        ack_lat = lat;
        @(posedge clk);
        #1;
        MemReadM_i   = rd_too;
        MemWriteM_i  = 1'b1;
        AddrM_i      = a;
        WriteDataM_i = d;
        wait_release("store", exp_stall);
        @(posedge clk);
        #1;
        MemReadM_i  = 1'b0;
        MemWriteM_i = 1'b0;
        ack_lat     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acks;
        rst_n        = 1'b0;
        MemReadM_i   = 1'b0;
        MemWriteM_i  = 1'b0;
        AddrM_i      = '0;
        WriteDataM_i = '0;
        for (int i = 0; i < 4; i++) begin
            mem[32'(32'h100 + 4 * i)] = 32'(32'hA0 + i);
            mem[32'(32'h200 + 4 * i)] = 32'(32'hB0 + i);
            mem[32'(32'h900 + 4 * i)] = 32'(32'h90 + i);
        end
        repeat (2) @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load(32'h100, 32'hA0, 1, 5);
        do_load(32'h108, 32'hA2, 0, 0);
        do_store(32'h104, 32'hDEADBEEF, 0, 3, 4);
        do_load(32'h104, 32'hDEADBEEF, 0, 0);

        do_store(32'h900, 32'h12345678, 0, 0, 1);
        do_load(32'h900, 32'h12345678, 1, 5);

        do_load(32'h100, 32'hA0, 1, 5);
        do_load(32'h200, 32'hB0, 1, 5);
        do_load(32'h100, 32'hA0, 1, 5);
        do_load(32'h10C, 32'hA3, 0, 0);

        do_store(32'h108, 32'h55AA55AA, 1, 0, 1);
        do_load(32'h108, 32'h55AA55AA, 0, 0);

        // Abandon a refill with reset during its third ack.
        for (int i = 0; i < 3; i++) exp_mem.push_back('{1'b0, 32'(32'h200 + 4 * i), 32'h0});
        @(posedge clk);
        #1;
        MemReadM_i = 1'b1;
        AddrM_i    = 32'h204;
        acks = 0;
        for (int k = 0; k < 100 && acks < 3; k++) begin
            @(negedge clk);
            if (mem_req_o && mem_ack_i) acks++;
        end
        chk("abort_ack_count", 32'(acks), 32'd3);
        #2;
        rst_n      = 1'b0;
        MemReadM_i = 1'b0;
        #1;
        chk("abort_req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("abort_stall", {31'd0, Stall_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks();

        do_load(32'h204, 32'hB1, 1, 5);
        do_load(32'h20C, 32'hB3, 0, 0);

        repeat (2) @(negedge clk);
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("exp_load_drained", 32'(exp_load.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
